// File: rtl/frame_burst_reader.sv
// Avalon-MM burst read master: streams a frame buffer from SDRAM into a pixel FIFO.
// Optional `FRAME_TAG_EN adds a start-of-frame tag bit as the MSB of data.
module frame_burst_reader #(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned PIX_W     = 24,
  parameter int unsigned PIX_LSB   = 32,
  parameter int unsigned BURST_LEN = 255,
  parameter int unsigned FIFO_AW   = 12,
  parameter int unsigned COOLDOWN  = 127
) (
  input  logic              clk_w,
  input  logic              rst,
  input  logic [31:0]       pio_address,
  input  logic [23:0]       pio_frame_words,
  input  logic              pio_ready,
  input  logic              start,
  output logic [ADDR_W-1:0] sdram0_address,
  output logic [7:0]        sdram0_burstcount,
  output logic              sdram0_read,
  input  logic              sdram0_waitrequest,
  input  logic [DATA_W-1:0] sdram0_readdata,
  input  logic              sdram0_readdatavalid,
  input  logic [FIFO_AW-1:0] usedw,
  output logic              wrreq,
`ifdef FRAME_TAG_EN
  output logic [PIX_W:0]    data,
`else
  output logic [PIX_W-1:0]  data,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

`ifdef FRAME_TAG_EN
  localparam int unsigned DO_W = PIX_W + 1;
`else
  localparam int unsigned DO_W = PIX_W;
`endif
  localparam int unsigned COOL_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int unsigned SUM_W    = FIFO_AW + 9;
  localparam int unsigned FIFO_MAX = (1 << FIFO_AW) - 1;

  typedef enum logic [2:0] {S_IDLE, S_COOL, S_LAUNCH, S_REQ, S_DATA, S_DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_ready, rr_ready, w_arm;
  logic [ADDR_W-1:0]   r_base, w_base_nxt, r_addr, w_addr_nxt, r_address, w_address_nxt;
  logic [23:0]         r_frame_words, w_fw_nxt, r_remaining, w_rem_nxt;
  logic [7:0]          r_bc, w_bc_nxt, r_cnt, w_cnt_nxt, r_burstcount, w_burstcount_nxt, w_bc;
  logic [COOL_W-1:0]   r_cool, w_cool_nxt;
  logic                r_read, w_read_nxt, r_wrreq, w_wrreq_nxt, r_busy, r_done, w_done_nxt;
  logic [DO_W-1:0]     r_data, w_data_nxt;
  logic [15:0]         r_frame_cnt, w_frame_cnt_nxt;
  logic [PIX_W-1:0]    w_pix;
  logic [SUM_W-1:0]    w_fill;
  logic                w_last, w_room, w_unused;
`ifdef FRAME_TAG_EN
  logic                r_first, w_first_nxt;
`endif

  assign w_arm    = !r_ready && pio_ready;
  assign w_bc     = (r_remaining > 24'(BURST_LEN)) ? 8'(BURST_LEN) : r_remaining[7:0];
  // Launch only when the whole burst is guaranteed to fit in the FIFO
  assign w_fill   = SUM_W'(usedw) + SUM_W'(w_bc);
  assign w_room   = w_fill < SUM_W'(FIFO_MAX);
  assign w_last   = (r_cnt == r_bc - 8'd1);
  assign w_pix    = sdram0_readdata[PIX_LSB +: PIX_W];
  assign w_unused = ^{pio_address, sdram0_readdata};

  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_addr_nxt       = r_addr;
    w_fw_nxt         = r_frame_words;
    w_rem_nxt        = r_remaining;
    w_bc_nxt         = r_bc;
    w_cnt_nxt        = r_cnt;
    w_cool_nxt       = r_cool;
    w_read_nxt       = r_read;
    w_address_nxt    = r_address;
    w_burstcount_nxt = r_burstcount;
    w_wrreq_nxt      = 1'b0;
    w_data_nxt       = r_data;
    w_done_nxt       = 1'b0;
    w_frame_cnt_nxt  = r_frame_cnt;
`ifdef FRAME_TAG_EN
    w_first_nxt      = r_first;
`endif
    case (r_state)
      S_IDLE: begin
        w_read_nxt = 1'b0;
        if (rr_ready && start) begin
          w_state_nxt = S_COOL;
          w_cool_nxt  = '0;
        end
      end
      S_COOL: begin
        if (!rr_ready)                           w_state_nxt = S_IDLE;
        else if (r_cool == COOL_W'(COOLDOWN))    w_state_nxt = S_LAUNCH;
        else                                     w_cool_nxt  = r_cool + COOL_W'(1);
      end
      S_LAUNCH: begin
        if (!rr_ready) begin
          w_state_nxt = S_IDLE;
        end else if (w_room) begin
          w_read_nxt       = 1'b1;
          w_address_nxt    = r_addr;
          w_burstcount_nxt = w_bc;
          w_bc_nxt         = w_bc;
          w_cnt_nxt        = 8'd0;
          w_state_nxt      = S_REQ;
        end
      end
      S_REQ: begin
        // An abort that coincides with command acceptance must still drain the burst
        if (!sdram0_waitrequest) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = rr_ready ? S_DATA : S_DRAIN;
        end else if (!rr_ready) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (!rr_ready) begin
          if (sdram0_readdatavalid && w_last) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
            if (sdram0_readdatavalid) w_cnt_nxt = r_cnt + 8'd1;
          end
        end else if (sdram0_readdatavalid) begin
          w_wrreq_nxt = 1'b1;
`ifdef FRAME_TAG_EN
          w_data_nxt  = {r_first, w_pix};
          w_first_nxt = 1'b0;
`else
          w_data_nxt  = w_pix;
`endif
          if (w_last) begin
            w_state_nxt = S_COOL;
            w_cool_nxt  = '0;
            if (r_remaining == 24'(r_bc)) begin
              w_addr_nxt      = r_base;
              w_rem_nxt       = r_frame_words;
              w_done_nxt      = 1'b1;
              w_frame_cnt_nxt = r_frame_cnt + 16'd1;
`ifdef FRAME_TAG_EN
              w_first_nxt     = 1'b1;
`endif
            end else begin
              w_addr_nxt = r_addr + ADDR_W'(r_bc);
              w_rem_nxt  = r_remaining - 24'(r_bc);
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (sdram0_readdatavalid) begin
          if (w_last) w_state_nxt = S_IDLE;
          else        w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A new arm edge reloads the frame; only DRAIN can see it without aborting
    if (w_arm) begin
      w_base_nxt = pio_address[ADDR_W-1:0];
      w_addr_nxt = pio_address[ADDR_W-1:0];
      w_fw_nxt   = pio_frame_words;
      w_rem_nxt  = pio_frame_words;
`ifdef FRAME_TAG_EN
      w_first_nxt = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_w) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b0;
      rr_ready      <= 1'b0;
      r_base        <= '0;
      r_addr        <= '0;
      r_frame_words <= '0;
      r_remaining   <= '0;
      r_bc          <= '0;
      r_cnt         <= '0;
      r_cool        <= '0;
      r_read        <= 1'b0;
      r_address     <= '0;
      r_burstcount  <= '0;
      r_wrreq       <= 1'b0;
      r_data        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_cnt   <= '0;
`ifdef FRAME_TAG_EN
      r_first       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_ready       <= pio_ready;
      rr_ready      <= r_ready;
      r_base        <= w_base_nxt;
      r_addr        <= w_addr_nxt;
      r_frame_words <= w_fw_nxt;
      r_remaining   <= w_rem_nxt;
      r_bc          <= w_bc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cool        <= w_cool_nxt;
      r_read        <= w_read_nxt;
      r_address     <= w_address_nxt;
      r_burstcount  <= w_burstcount_nxt;
      r_wrreq       <= w_wrreq_nxt;
      r_data        <= w_data_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
`ifdef FRAME_TAG_EN
      r_first       <= w_first_nxt;
`endif
    end
  end

  assign sdram0_address    = r_address;
  assign sdram0_burstcount = r_burstcount;
  assign sdram0_read       = r_read;
  assign wrreq             = r_wrreq;
  assign data              = r_data;
  assign busy              = r_busy;
  assign frame_done        = r_done;
  assign frame_cnt         = r_frame_cnt;

endmodule

// File: tb/tb_frame_burst_reader.sv
// Directed bench for frame_burst_reader (BURST_LEN=4, COOLDOWN=0, pixel at readdata[47:24]).
module tb_frame_burst_reader;
  localparam int unsigned AW = 29;

  logic          clk_w = 1'b0;
  logic          rst;
  logic [31:0]   pio_address;
  logic [23:0]   pio_frame_words;
  logic          pio_ready, start;
  logic [AW-1:0] sdram0_address;
  logic [7:0]    sdram0_burstcount;
  logic          sdram0_read, sdram0_waitrequest;
  logic [63:0]   sdram0_readdata;
  logic          sdram0_readdatavalid;
  logic [11:0]   usedw;
  logic          wrreq;
`ifdef FRAME_TAG_EN
  logic [24:0]   data;
`else
  logic [23:0]   data;
`endif
  logic          busy, frame_done;
  logic [15:0]   frame_cnt;

  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            n_acc   = 0;
  logic [23:0]   k       = 24'h100000;

  frame_burst_reader #(
    .ADDR_W(29), .DATA_W(64), .PIX_W(24), .PIX_LSB(24),
    .BURST_LEN(4), .FIFO_AW(12), .COOLDOWN(0)
  ) dut (
    .clk_w(clk_w), .rst(rst),
    .pio_address(pio_address), .pio_frame_words(pio_frame_words),
    .pio_ready(pio_ready), .start(start),
    .sdram0_address(sdram0_address), .sdram0_burstcount(sdram0_burstcount),
    .sdram0_read(sdram0_read), .sdram0_waitrequest(sdram0_waitrequest),
    .sdram0_readdata(sdram0_readdata), .sdram0_readdatavalid(sdram0_readdatavalid),
    .usedw(usedw), .wrreq(wrreq), .data(data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk_w = ~clk_w;

  // Commands accepted by the interconnect
  always @(posedge clk_w) begin
    if (rst) n_acc <= 0;
    else if (sdram0_read && !sdram0_waitrequest) n_acc <= n_acc + 1;
  end

  task automatic tick();
    @(negedge clk_w);
  endtask

  function automatic logic [63:0] mk(input logic [23:0] p);
    return {16'hA5A5, p, 24'h5A5A5A};
  endfunction

  task automatic word(input logic [63:0] d);
    sdram0_readdatavalid = 1'b1;
    sdram0_readdata      = d;
    tick();
    sdram0_readdatavalid = 1'b0;
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sdram0_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pio_address = '0; pio_frame_words = '0; pio_ready = 1'b0; start = 1'b0;
    sdram0_waitrequest = 1'b0; sdram0_readdata = '0; sdram0_readdatavalid = 1'b0; usedw = '0;
    tick(); tick();
    vec_cnt++;
    if ({sdram0_read, wrreq, busy, frame_done} !== 4'b0) begin
      err_cnt++; $display("FAIL reset_ctl: got %b expected 0000", {sdram0_read, wrreq, busy, frame_done});
    end
    vec_cnt++;
    if (sdram0_address !== '0 || sdram0_burstcount !== 8'd0) begin
      err_cnt++; $display("FAIL reset_cmd: got addr %h bc %0d expected 0/0", sdram0_address, sdram0_burstcount);
    end
    vec_cnt++;
    if (frame_cnt !== 16'd0 || data[23:0] !== 24'd0) begin
      err_cnt++; $display("FAIL reset_data: got cnt %0d data %h expected 0/0", frame_cnt, data[23:0]);
    end
    rst = 1'b0;
  endtask

  task automatic test_frame_bursts();
    logic [AW-1:0] ea [3];
    logic [7:0]    eb [3];
    bit            ok;
    ea = '{29'h100, 29'h104, 29'h108};
    eb = '{8'd4, 8'd4, 8'd2};
    pio_address = 32'h100; pio_frame_words = 24'd10; pio_ready = 1'b1; start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      wait_cmd(ok);
      vec_cnt++;
      if (!ok || sdram0_address !== ea[b] || sdram0_burstcount !== eb[b]) begin
        err_cnt++;
        $display("FAIL burst%0d_cmd: got read %b addr %h bc %0d expected addr %h bc %0d",
                 b, sdram0_read, sdram0_address, sdram0_burstcount, ea[b], eb[b]);
      end
      tick();
      vec_cnt++;
      if (sdram0_read !== 1'b0 || busy !== 1'b1) begin
        err_cnt++; $display("FAIL burst%0d_accept: got read %b busy %b expected 0/1", b, sdram0_read, busy);
      end
      for (int w = 0; w < int'(eb[b]); w++) begin
        word(mk(k));
        vec_cnt++;
        if (wrreq !== 1'b1 || data[23:0] !== k) begin
          err_cnt++; $display("FAIL burst%0d_word%0d: got wrreq %b data %h expected 1/%h", b, w, wrreq, data[23:0], k);
        end
        k++;
      end
    end
    vec_cnt++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
      err_cnt++; $display("FAIL frame_end: got done %b cnt %0d expected 1/1", frame_done, frame_cnt);
    end
  endtask

  task automatic test_waitrequest();
    bit ok, stable;
    int acc0;
    sdram0_waitrequest = 1'b1;
    tick();
    vec_cnt++;
    if (frame_done !== 1'b0) begin
      err_cnt++; $display("FAIL done_pulse_width: got %b expected 0", frame_done);
    end
    wait_cmd(ok);
    vec_cnt++;
    if (!ok || sdram0_address !== 29'h100 || sdram0_burstcount !== 8'd4) begin
      err_cnt++; $display("FAIL frame_restart_cmd: got addr %h bc %0d expected 100/4", sdram0_address, sdram0_burstcount);
    end
    acc0 = n_acc;
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (sdram0_read !== 1'b1 || sdram0_address !== 29'h100 || sdram0_burstcount !== 8'd4) stable = 1'b0;
    end
    vec_cnt++;
    if (stable !== 1'b1) begin
      err_cnt++; $display("FAIL wait_hold: got unstable command, expected read/addr/bc held");
    end
    sdram0_waitrequest = 1'b0;
    tick();
    vec_cnt++;
    if (sdram0_read !== 1'b0 || n_acc !== acc0 + 1) begin
      err_cnt++; $display("FAIL wait_accept: got read %b accepted %0d expected 0/1", sdram0_read, n_acc - acc0);
    end
    for (int w = 0; w < 4; w++) begin
      if (w == 3) usedw = 12'd4091;   // 4091+4 = 4095: not strictly below 4095
      word(mk(k));
      vec_cnt++;
      if (wrreq !== 1'b1 || data[23:0] !== k) begin
        err_cnt++; $display("FAIL wait_word%0d: got wrreq %b data %h expected 1/%h", w, wrreq, data[23:0], k);
      end
      k++;
    end
  endtask

  task automatic test_fifo_backpressure();
    bit seen = 1'b0;
    repeat (8) begin
      tick();
      if (sdram0_read !== 1'b0) seen = 1'b1;
    end
    vec_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++; $display("FAIL fifo_full_hold: got read while usedw=4091 expected none");
    end
    usedw = 12'd4090;
    tick();
    vec_cnt++;
    if (sdram0_read !== 1'b1 || sdram0_address !== 29'h104 || sdram0_burstcount !== 8'd4) begin
      err_cnt++; $display("FAIL fifo_room_launch: got read %b addr %h bc %0d expected 1/104/4",
                          sdram0_read, sdram0_address, sdram0_burstcount);
    end
    usedw = 12'd0;
    tick();
  endtask

  task automatic test_readdata_slice();
    word(64'h00AABBCC_DDEEFF11);
    vec_cnt++;
    if (wrreq !== 1'b1 || data[23:0] !== 24'hBBCCDD) begin
      err_cnt++; $display("FAIL pixel_slice: got wrreq %b data %h expected 1/bbccdd", wrreq, data[23:0]);
    end
  endtask

  task automatic test_abort_drain();
    word(mk(k));
    vec_cnt++;
    if (wrreq !== 1'b1 || data[23:0] !== k) begin
      err_cnt++; $display("FAIL pre_abort_word: got wrreq %b data %h expected 1/%h", wrreq, data[23:0], k);
    end
    k++;
    pio_ready = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++; $display("FAIL drain_busy: got %b expected 1", busy);
    end
    word(mk(k));
    vec_cnt++;
    if (wrreq !== 1'b0) begin
      err_cnt++; $display("FAIL drain_word0: got wrreq %b expected 0", wrreq);
    end
    word(mk(k));
    vec_cnt++;
    if (wrreq !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL drain_word1: got wrreq %b busy %b expected 0/0", wrreq, busy);
    end
    repeat (5) tick();
    vec_cnt++;
    if (sdram0_read !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL idle_after_abort: got read %b busy %b expected 0/0", sdram0_read, busy);
    end
  endtask

  task automatic test_addr_wrap();
    bit ok;
    pio_address = 32'h1FFF_FFFE; pio_frame_words = 24'd10; pio_ready = 1'b1;
    wait_cmd(ok);
    vec_cnt++;
    if (!ok || sdram0_address !== 29'h1FFF_FFFE || sdram0_burstcount !== 8'd4) begin
      err_cnt++; $display("FAIL wrap_first_cmd: got addr %h bc %0d expected 1ffffffe/4", sdram0_address, sdram0_burstcount);
    end
    tick();
    sdram0_waitrequest = 1'b1;
    for (int w = 0; w < 4; w++) begin
      word(mk(k));
      k++;
    end
    wait_cmd(ok);
    vec_cnt++;
    if (!ok || sdram0_address !== 29'h2 || sdram0_burstcount !== 8'd4) begin
      err_cnt++; $display("FAIL wrap_second_cmd: got addr %h bc %0d expected 2/4", sdram0_address, sdram0_burstcount);
    end
  endtask

  task automatic test_reset_mid_req();
    repeat (2) tick();
    vec_cnt++;
    if (sdram0_read !== 1'b1 || busy !== 1'b1 || frame_cnt !== 16'd1) begin
      err_cnt++; $display("FAIL req_pending: got read %b busy %b cnt %0d expected 1/1/1", sdram0_read, busy, frame_cnt);
    end
    rst = 1'b1;
    tick();
    vec_cnt++;
    if ({sdram0_read, wrreq, busy, frame_done} !== 4'b0 || sdram0_address !== '0 ||
        sdram0_burstcount !== 8'd0 || frame_cnt !== 16'd0 || data[23:0] !== 24'd0) begin
      err_cnt++; $display("FAIL mid_req_reset: got read %b wrreq %b busy %b done %b addr %h bc %0d cnt %0d expected all 0",
                          sdram0_read, wrreq, busy, frame_done, sdram0_address, sdram0_burstcount, frame_cnt);
    end
    rst = 1'b0;
    sdram0_waitrequest = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_bursts();
    test_waitrequest();
    test_fifo_backpressure();
    test_readdata_slice();
    test_abort_drain();
    test_addr_wrap();
    test_reset_mid_req();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
